// File: rtl/processor_pkg.sv
// processor_pkg: shared word width, register-file size and ALU opcode
// encodings for the Blueberry-Pi datapath and its controller.
package processor_pkg;

  localparam int WORD_W   = 10;
  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;
  localparam int TS_W     = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_INV  = 4'd2,
    ALU_FLP  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_LSL  = 4'd7,
    ALU_LSR  = 4'd8,
    ALU_ASR  = 4'd9,
    ALU_ADDI = 4'd10,
    ALU_SUBI = 4'd11,
    ALU_PASS = 4'd12,
    ALU_ZERO = 4'd15
  } alu_op_t;

  // True when at least two of the three bus drivers are requested at once.
  function automatic logic multi_driver(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/processor_alu.sv
// processor_alu: purely combinational ALU. B is the current bus value, IMM
// the controller immediate. Shift amounts use all of B, so anything past
// the word width saturates instead of wrapping.
module processor_alu
  import processor_pkg::*;
(
  input  word_t   A,
  input  word_t   B,
  input  word_t   IMM,
  input  alu_op_t op,
  output word_t   result
);

  logic       shift_over;
  logic [3:0] shamt;

  assign shift_over = (B > word_t'(WORD_W - 1));
  assign shamt      = B[3:0];

  // Select the operation result; unused encodings produce zero.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = A + B;
      ALU_SUB:  result = A - B;
      ALU_INV:  result = '0 - B;
      ALU_FLP:  result = ~B;
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_XOR:  result = A ^ B;
      ALU_LSL:  result = shift_over ? '0 : (A << shamt);
      ALU_LSR:  result = shift_over ? '0 : (A >> shamt);
      ALU_ASR:  result = shift_over ? {WORD_W{A[WORD_W-1]}} : word_t'($signed(A) >>> shamt);
      ALU_ADDI: result = A + IMM;
      ALU_SUBI: result = A - IMM;
      ALU_PASS: result = B;
      ALU_ZERO: result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/processor_datapath.sv
// processor_datapath: executes one control word per cycle for the
// Blueberry-Pi core. Owns the shared bus mux, the four-entry register file,
// the A/G/IR latches, the timestep counter and the sticky bus-conflict flag.
module processor_datapath
  import processor_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  Data,
  input  logic [WIDTH-1:0]  IMM,
  input  logic [REG_AW-1:0] Rin,
  input  logic [REG_AW-1:0] Rout,
  input  logic              ENW,
  input  logic              ENR,
  input  logic              Ain,
  input  logic              Gin,
  input  logic              Gout,
  input  logic [3:0]        ALUcont,
  input  logic              Ext,
  input  logic              IRin,
  input  logic              Clr,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [WIDTH-1:0]  IR,
  output logic [TS_W-1:0]   timestep,
  output logic [WIDTH-1:0]  bus,
  output logic [WIDTH-1:0]  dbg_reg,
  output logic              bus_conflict
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] ir_reg;
  logic [TS_W-1:0]  ts_reg;
  logic             conflict_q;
  logic [WIDTH-1:0] bus_val;
  logic [WIDTH-1:0] alu_result;
  logic             multi_drive;
  alu_op_t          alu_op;

  assign alu_op      = alu_op_t'(ALUcont);
  assign multi_drive = multi_driver(Ext, Gout, ENR);

  // Shared bus: external switches win over G, which wins over the register file.
  always_comb begin
    bus_val = '0;
    if (Ext) begin
      bus_val = Data;
    end else if (Gout) begin
      bus_val = g_reg;
    end else if (ENR) begin
      bus_val = regs[Rout];
    end
  end

  processor_alu u_alu (
    .A      (a_reg),
    .B      (bus_val),
    .IMM    (IMM),
    .op     (alu_op),
    .result (alu_result)
  );

  // Register file write port; a same-cycle read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (ENW) begin
      regs[Rin] <= bus_val;
    end
  end

  // A operand latch; the ALU keeps seeing the old A during a load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg <= '0;
    end else if (Ain) begin
      a_reg <= bus_val;
    end
  end

  // G result latch; may capture while its old value is on the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      g_reg <= '0;
    end else if (Gin) begin
      g_reg <= alu_result;
    end
  end

  // Instruction register loads straight from the switches, bypassing the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_reg <= '0;
    end else if (IRin) begin
      ir_reg <= Data;
    end
  end

  // Free-running timestep counter; Clr restarts the instruction at step 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_reg <= '0;
    end else if (Clr) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
    end
  end

  // Sticky record of any cycle with contending bus drivers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      conflict_q <= 1'b0;
    end else if (multi_drive) begin
      conflict_q <= 1'b1;
    end
  end

  assign bus          = bus_val;
  assign dbg_reg      = regs[dbg_sel];
  assign IR           = ir_reg;
  assign timestep     = ts_reg;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_processor_datapath.sv
// tb_processor_datapath: directed vector table plus randomized control words
// checked against an arithmetic reference model of the datapath.
module tb_processor_datapath;
  import processor_pkg::*;

  localparam logic [7:0] F_EXT  = 8'h80;
  localparam logic [7:0] F_GOUT = 8'h40;
  localparam logic [7:0] F_ENR  = 8'h20;
  localparam logic [7:0] F_ENW  = 8'h10;
  localparam logic [7:0] F_AIN  = 8'h08;
  localparam logic [7:0] F_GIN  = 8'h04;
  localparam logic [7:0] F_IRIN = 8'h02;
  localparam logic [7:0] F_CLR  = 8'h01;
  localparam logic [7:0] F_NONE = 8'h00;

  typedef struct {
    logic [7:0] flags;
    logic [1:0] rin;
    logic [1:0] rout;
    logic [1:0] dsel;
    logic [3:0] op;
    logic [9:0] data;
    logic [9:0] imm;
    logic [9:0] expBus;
    logic [9:0] expDbg;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [9:0] Data, IMM;
  logic [1:0] Rin, Rout, dbg_sel;
  logic       ENW, ENR, Ain, Gin, Gout, Ext, IRin, Clr;
  logic [3:0] ALUcont;
  logic [9:0] IR, bus, dbg_reg;
  logic [1:0] timestep;
  logic       bus_conflict;

  logic [9:0] mReg [4];
  logic [9:0] mA, mG, mIr;
  logic [1:0] mTs;
  logic       mConf;

  int vecCount;
  int missCount;

  processor_datapath dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .Data         (Data),
    .IMM          (IMM),
    .Rin          (Rin),
    .Rout         (Rout),
    .ENW          (ENW),
    .ENR          (ENR),
    .Ain          (Ain),
    .Gin          (Gin),
    .Gout         (Gout),
    .ALUcont      (ALUcont),
    .Ext          (Ext),
    .IRin         (IRin),
    .Clr          (Clr),
    .dbg_sel      (dbg_sel),
    .IR           (IR),
    .timestep     (timestep),
    .bus          (bus),
    .dbg_reg      (dbg_reg),
    .bus_conflict (bus_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [7:0] f, input logic [1:0] rin, input logic [1:0] rout,
                                 input logic [1:0] dsel, input logic [3:0] op, input logic [9:0] data,
                                 input logic [9:0] imm, input logic [9:0] expBus, input logic [9:0] expDbg);
    vec_t v;
    v.flags = f; v.rin = rin; v.rout = rout; v.dsel = dsel; v.op = op;
    v.data = data; v.imm = imm; v.expBus = expBus; v.expDbg = expDbg;
    return v;
  endfunction

  function automatic vec_t idleVec();
    return mkVec(F_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 10'h000, 10'h000, 10'h000, 10'h000);
  endfunction

  // Reference ALU written from the operation rules with integer arithmetic.
  function automatic logic [9:0] refAlu(input int op, input int a, input int b, input int imm);
    int r;
    int sa;
    int sh;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = -b;
      3:  r = ~b;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = (b >= 10) ? 0 : (a << b);
      8:  r = (b >= 10) ? 0 : (a >> b);
      9: begin
        sa = (a >= 512) ? (a - 1024) : a;
        sh = (b > 31) ? 31 : b;
        r  = sa >>> sh;
      end
      10: r = a + imm;
      11: r = a - imm;
      12: r = b;
      default: r = 0;
    endcase
    return r[9:0];
  endfunction

  function automatic logic [9:0] refBus();
    if (Ext)       return Data;
    else if (Gout) return mG;
    else if (ENR)  return mReg[Rout];
    else           return 10'h000;
  endfunction

  task automatic checkVal(input string name, input logic [9:0] act, input logic [9:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the reference model across one rising edge using the held inputs.
  task automatic modelEdge();
    logic [9:0] b;
    int drivers;
    b = refBus();
    drivers = int'(Ext) + int'(Gout) + int'(ENR);
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mReg[i] = 10'h000;
      mA = 10'h000; mG = 10'h000; mIr = 10'h000; mTs = 2'd0; mConf = 1'b0;
    end else begin
      if (Gin) mG = refAlu(int'(ALUcont), int'(mA), int'(b), int'(IMM));
      if (ENW) mReg[Rin] = b;
      if (Ain) mA = b;
      if (IRin) mIr = Data;
      mTs = Clr ? 2'd0 : 2'((int'(mTs) + 1) % 4);
      if (drivers >= 2) mConf = 1'b1;
    end
  endtask

  task automatic driveInputs(input vec_t v, input logic rstN);
    reset_n = rstN;
    Ext  = v.flags[7]; Gout = v.flags[6]; ENR = v.flags[5]; ENW  = v.flags[4];
    Ain  = v.flags[3]; Gin  = v.flags[2]; IRin = v.flags[1]; Clr = v.flags[0];
    Rin = v.rin; Rout = v.rout; dbg_sel = v.dsel; ALUcont = v.op;
    Data = v.data; IMM = v.imm;
  endtask

  task automatic checkOutput(input bit afterEdge);
    if (!afterEdge) begin
      checkVal("bus", bus, refBus());
      checkVal("dbg_reg", dbg_reg, mReg[dbg_sel]);
    end else begin
      checkVal("IR", IR, mIr);
      checkVal("timestep", 10'(timestep), 10'(mTs));
      checkVal("bus_conflict", 10'(bus_conflict), 10'(mConf));
      checkVal("dbg_reg post", dbg_reg, mReg[dbg_sel]);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic rstN);
    driveInputs(v, rstN);
    #1;
    checkOutput(1'b0);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(1'b1);
  endtask

  task automatic sweepRegs();
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      checkVal("reg sweep", dbg_reg, mReg[s]);
    end
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [1:0] tsExp [4];

  initial begin
    vecCount  = 0;
    missCount = 0;
    for (int i = 0; i < 4; i++) mReg[i] = 10'h000;
    mA = 10'h000; mG = 10'h000; mIr = 10'h000; mTs = 2'd0; mConf = 1'b0;
    tsExp = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held for two edges while junk controls are asserted.
    v = mkVec(F_EXT | F_GOUT | F_ENW | F_GIN | F_IRIN, 2'd1, 2'd0, 2'd0, 4'd0, 10'h3FF, 10'h3FF, 10'h000, 10'h000);
    driveInputs(v, 1'b0);
    repeat (2) begin
      @(posedge clk);
      modelEdge();
    end
    #1;
    driveInputs(idleVec(), 1'b0);
    #1;
    checkVal("reset bus", bus, 10'h000);
    checkVal("reset IR", IR, 10'h000);
    checkVal("reset timestep", 10'(timestep), 10'h000);
    checkVal("reset bus_conflict", 10'(bus_conflict), 10'h000);
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      checkVal("reset reg", dbg_reg, 10'h000);
    end

    // Release: G reads zero and the counter counts 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      v = idleVec();
      if (k == 0) v.flags = F_GOUT;
      applyStimulus(v, 1'b1);
      if (k == 0) checkVal("reset G", bus, 10'h000);
      clockEdge();
      checkVal("release timestep", 10'(timestep), 10'(tsExp[k]));
    end

    // Directed vector table: loads, add, immediates, shifts, same-cycle hazards.
    tbl.push_back(mkVec(F_EXT | F_ENW,  2'd0, 2'd0, 2'd0, ALU_ADD,  10'h005, 10'h000, 10'h005, 10'h005));
    tbl.push_back(mkVec(F_EXT | F_ENW,  2'd1, 2'd0, 2'd1, ALU_ADD,  10'h003, 10'h000, 10'h003, 10'h003));
    tbl.push_back(mkVec(F_ENR | F_AIN,  2'd0, 2'd0, 2'd0, ALU_ADD,  10'h000, 10'h000, 10'h005, 10'h005));
    tbl.push_back(mkVec(F_ENR | F_GIN,  2'd0, 2'd1, 2'd1, ALU_ADD,  10'h000, 10'h000, 10'h003, 10'h003));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd0, 2'd0, 2'd0, ALU_ADD,  10'h000, 10'h000, 10'h008, 10'h008));
    tbl.push_back(mkVec(F_EXT | F_AIN,  2'd0, 2'd0, 2'd2, ALU_ADD,  10'h004, 10'h000, 10'h004, 10'h000));
    tbl.push_back(mkVec(F_GIN,          2'd0, 2'd0, 2'd2, ALU_SUBI, 10'h000, 10'h002, 10'h000, 10'h000));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd2, 2'd0, 2'd2, ALU_ADD,  10'h000, 10'h000, 10'h002, 10'h002));
    tbl.push_back(mkVec(F_EXT | F_AIN,  2'd0, 2'd0, 2'd3, ALU_ADD,  10'h001, 10'h000, 10'h001, 10'h000));
    tbl.push_back(mkVec(F_GIN,          2'd0, 2'd0, 2'd3, ALU_SUBI, 10'h000, 10'h003, 10'h000, 10'h000));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd3, 2'd0, 2'd3, ALU_ADD,  10'h000, 10'h000, 10'h3FE, 10'h3FE));
    tbl.push_back(mkVec(F_EXT | F_AIN,  2'd0, 2'd0, 2'd3, ALU_ADD,  10'h201, 10'h000, 10'h201, 10'h3FE));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd3, ALU_LSL,  10'h001, 10'h000, 10'h001, 10'h3FE));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd1, 2'd0, 2'd1, ALU_ADD,  10'h000, 10'h000, 10'h002, 10'h002));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd1, ALU_LSR,  10'h001, 10'h000, 10'h001, 10'h002));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd1, 2'd0, 2'd1, ALU_ADD,  10'h000, 10'h000, 10'h100, 10'h100));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd1, ALU_ASR,  10'h001, 10'h000, 10'h001, 10'h100));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd1, 2'd0, 2'd1, ALU_ADD,  10'h000, 10'h000, 10'h300, 10'h300));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd1, ALU_ASR,  10'h00C, 10'h000, 10'h00C, 10'h300));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd1, 2'd0, 2'd1, ALU_ADD,  10'h000, 10'h000, 10'h3FF, 10'h3FF));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd1, ALU_LSL,  10'h00C, 10'h000, 10'h00C, 10'h3FF));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd1, 2'd0, 2'd1, ALU_ADD,  10'h000, 10'h000, 10'h000, 10'h000));
    tbl.push_back(mkVec(F_ENR | F_ENW,  2'd0, 2'd0, 2'd0, ALU_ADD,  10'h000, 10'h000, 10'h008, 10'h008));
    tbl.push_back(mkVec(F_GOUT | F_GIN, 2'd0, 2'd0, 2'd0, ALU_ADDI, 10'h000, 10'h005, 10'h000, 10'h008));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd2, 2'd0, 2'd2, ALU_ADD,  10'h000, 10'h000, 10'h206, 10'h206));
    tbl.push_back(mkVec(F_EXT | F_AIN | F_GIN, 2'd0, 2'd0, 2'd2, ALU_ADD, 10'h010, 10'h000, 10'h010, 10'h206));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd3, 2'd0, 2'd3, ALU_ADD,  10'h000, 10'h000, 10'h211, 10'h211));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd3, ALU_ADD,  10'h001, 10'h000, 10'h001, 10'h211));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd3, 2'd0, 2'd3, ALU_ADD,  10'h000, 10'h000, 10'h011, 10'h011));
    tbl.push_back(mkVec(F_EXT | F_AIN,  2'd0, 2'd0, 2'd0, ALU_ADD,  10'h0F0, 10'h000, 10'h0F0, 10'h008));
    tbl.push_back(mkVec(F_EXT | F_GIN,  2'd0, 2'd0, 2'd0, ALU_AND,  10'h0FF, 10'h000, 10'h0FF, 10'h008));
    tbl.push_back(mkVec(F_GOUT | F_ENW, 2'd2, 2'd0, 2'd2, ALU_ADD,  10'h000, 10'h000, 10'h0F0, 10'h0F0));
    tbl.push_back(mkVec(F_IRIN,         2'd0, 2'd0, 2'd0, ALU_ADD,  10'h2AB, 10'h000, 10'h000, 10'h008));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i], 1'b1);
      checkVal($sformatf("table[%0d] bus", i), bus, tbl[i].expBus);
      clockEdge();
      checkVal($sformatf("table[%0d] dbg", i), dbg_reg, tbl[i].expDbg);
      sweepRegs();
    end
    checkVal("IR load", IR, 10'h2AB);

    // Clr at timestep 2 and at timestep 3 both land on 0.
    for (int k = 0; k < 4 && mTs != 2'd2; k++) begin
      applyStimulus(idleVec(), 1'b1);
      clockEdge();
    end
    checkVal("reach timestep 2", 10'(timestep), 10'h002);
    v = idleVec(); v.flags = F_CLR;
    applyStimulus(v, 1'b1);
    clockEdge();
    checkVal("clr at 2", 10'(timestep), 10'h000);
    for (int k = 0; k < 4 && mTs != 2'd3; k++) begin
      applyStimulus(idleVec(), 1'b1);
      clockEdge();
    end
    checkVal("reach timestep 3", 10'(timestep), 10'h003);
    applyStimulus(v, 1'b1);
    clockEdge();
    checkVal("clr at 3", 10'(timestep), 10'h000);

    // Bus conflict: Ext beats Gout, flag sticks until reset.
    checkVal("no conflict yet", 10'(bus_conflict), 10'h000);
    applyStimulus(mkVec(F_EXT | F_AIN, 2'd0, 2'd0, 2'd0, ALU_ADD, 10'h055, 10'h000, 10'h000, 10'h000), 1'b1);
    clockEdge();
    applyStimulus(mkVec(F_EXT | F_GIN, 2'd0, 2'd0, 2'd0, ALU_ADD, 10'h000, 10'h000, 10'h000, 10'h000), 1'b1);
    clockEdge();
    applyStimulus(mkVec(F_EXT | F_GOUT, 2'd0, 2'd0, 2'd0, ALU_ADD, 10'h0AA, 10'h000, 10'h000, 10'h000), 1'b1);
    checkVal("conflict bus", bus, 10'h0AA);
    clockEdge();
    checkVal("conflict set", 10'(bus_conflict), 10'h001);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(idleVec(), 1'b1);
      clockEdge();
      checkVal("conflict sticky", 10'(bus_conflict), 10'h001);
    end
    applyStimulus(idleVec(), 1'b0);
    clockEdge();
    checkVal("conflict cleared", 10'(bus_conflict), 10'h000);

    // Randomized control words, including occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      v = idleVec();
      v.flags[7] = ($urandom_range(0, 3) == 0);
      v.flags[6] = ($urandom_range(0, 3) == 0);
      v.flags[5] = ($urandom_range(0, 2) == 0);
      v.flags[4] = ($urandom_range(0, 1) == 0);
      v.flags[3] = ($urandom_range(0, 2) == 0);
      v.flags[2] = ($urandom_range(0, 1) == 0);
      v.flags[1] = ($urandom_range(0, 5) == 0);
      v.flags[0] = ($urandom_range(0, 5) == 0);
      v.rin  = 2'($urandom_range(0, 3));
      v.rout = 2'($urandom_range(0, 3));
      v.dsel = 2'($urandom_range(0, 3));
      v.op   = 4'($urandom_range(0, 15));
      v.data = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      v.imm  = 10'($urandom_range(0, 1023));
      applyStimulus(v, ($urandom_range(0, 19) != 0));
      clockEdge();
      sweepRegs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
